// File: rtl/tm_mul_rr_arbiter.sv
// Round-robin arbiter that shares one truncated array multiplier among N_REQ requesters.
// Latency: a grant in cycle c gives the product on rsp_* in cycle c+2, one op/cycle sustained.
// Backpressure: with rsp_ready low, S2 then S1 fill and req_ready drops; they refill in the release cycle.

module tm_trunc_mul #(
    parameter int WIDTH = 8,
    parameter int K     = 3
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod
);
    // Partial products with either index below K are never generated.
    always_comb begin
        prod = '0;
        for (int i = K; i < WIDTH; i++) begin
            for (int j = K; j < WIDTH; j++) begin
                if (a[i] && b[j]) begin
                    prod = prod + ((2*WIDTH)'(1) << (i + j));
                end
            end
        end
    end
endmodule

module tm_mul_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int K     = 3,
    parameter int IDW   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_prod,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy,
    output logic [15:0]            ops_count
);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    logic               s1_valid;
    s1_t                s1;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_next;
    logic [IDW-1:0]     gnt_id;
    logic [IDW:0]       cand;
    logic               gnt_found;
    logic               grant;
    logic               s2_load;
    logic               s1_free;
    logic [2*WIDTH-1:0] mul_prod;

    assign s2_load = s1_valid && (!rsp_valid || rsp_ready);
    assign s1_free = !s1_valid || s2_load;
    assign busy    = s1_valid || rsp_valid;

    // Circular search starting at rr_ptr; cand is one bit wider so the wrap is a single subtract.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[IDW-1:0];
            end
        end
    end

    assign grant     = gnt_found && s1_free && !rst;
    assign req_ready = grant ? (N_REQ'(1) << gnt_id) : '0;
    assign rr_next   = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);

    tm_trunc_mul #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_mul (
        .a    (s1.a),
        .b    (s1.b),
        .prod (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_prod  <= '0;
            rsp_id    <= '0;
            ops_count <= '0;
        end else begin
            if (grant) begin
                s1_valid <= 1'b1;
                s1.id    <= gnt_id;
                s1.a     <= req_a[gnt_id*WIDTH +: WIDTH];
                s1.b     <= req_b[gnt_id*WIDTH +: WIDTH];
                rr_ptr   <= rr_next;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                rsp_valid <= 1'b1;
                rsp_prod  <= mul_prod;
                rsp_id    <= s1.id;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            if (rsp_valid && rsp_ready && ops_count != 16'hFFFF) begin
                ops_count <= ops_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tm_mul_rr_arbiter.sv
// Bench for tm_mul_rr_arbiter: an in-order queue model checked every cycle,
// directed cases pinned to literal values, then randomized traffic.
module tb_tm_mul_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [15:0]    rsp_prod;
    logic [1:0]     rsp_id;
    logic           busy;
    logic [15:0]    ops_count;

    int n_pass  = 0;
    int n_total = 0;

    tm_mul_rr_arbiter #(.N_REQ(4), .WIDTH(8), .K(3), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int prod;
        int cyc;
    } op_t;

    op_t q[$];
    op_t acc_log[$];
    int  gnt_log[$];
    int  rr  = 0;
    int  cnt = 0;
    int  cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int model_prod(input int a, input int b);
        return ((a >> 3) * (b >> 3)) << 6;
    endfunction

    // Ops leave in grant order; the head is visible two cycles after its grant.
    // A grant is possible while fewer than two ops would remain after this cycle's accept.
    always @(negedge clk) begin
        bit  exp_vld;
        bit  accept;
        bit  found;
        int  g;
        int  idx;
        op_t op;
        exp_vld = (q.size() > 0) && (cyc >= q[0].cyc + 2);
        accept  = exp_vld && (rsp_ready === 1'b1);
        found   = 1'b0;
        g       = 0;
        if (rst !== 1'b1 && (q.size() - int'(accept)) < 2) begin
            for (int i = 0; i < N; i++) begin
                idx = (rr + i) % N;
                if (!found && req_valid[idx] === 1'b1) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
        chk("req_ready", req_ready, found ? (32'd1 << g) : 32'd0);
        chk("rsp_valid", rsp_valid, exp_vld);
        chk("busy", busy, q.size() > 0);
        chk("ops_count", ops_count, cnt);
        if (exp_vld) begin
            chk("rsp_prod", rsp_prod, q[0].prod);
            chk("rsp_id", rsp_id, q[0].id);
        end
        if (rst === 1'b1) begin
            q.delete();
            rr  = 0;
            cnt = 0;
        end else begin
            if (accept) begin
                op = q.pop_front();
                acc_log.push_back('{op.id, op.prod, cyc});
                if (cnt < 65535) cnt++;
            end
            if (found) begin
                q.push_back('{g, model_prod(int'(req_a[g*W +: W]), int'(req_b[g*W +: W])), cyc});
                gnt_log.push_back(g);
                rr = (g + 1) % N;
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_op(input int r, input int a, input int b);
        req_a[r*W +: W] = 8'(a);
        req_b[r*W +: W] = 8'(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] pend;
        logic [N-1:0] gnt_seen;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset ops_count", ops_count, 0);
        chk("reset rsp_prod", rsp_prod, 0);
        chk("reset rsp_id", rsp_id, 0);

        // Single op from requester 2
        step();
        req_valid = 4'b0100;
        set_op(2, 'hFF, 'hFF);
        @(negedge clk);
        chk("single req_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        chk("single rsp_valid", rsp_valid, 1);
        chk("single rsp_prod", rsp_prod, 16'hF040);
        chk("single rsp_id", rsp_id, 2);
        step();
        @(negedge clk);
        chk("single ops_count", ops_count, 1);

        // Truncation edges, back-to-back from requester 0
        step();
        acc_log.delete();
        req_valid = 4'b0001;
        set_op(0, 'h07, 'hFF);
        step();
        set_op(0, 'h08, 'h08);
        step();
        set_op(0, 'h80, 'h80);
        step();
        req_valid = '0;
        idle(4);
        chk("b2b count", acc_log.size(), 3);
        if (acc_log.size() == 3) begin
            chk("trunc 07xFF", acc_log[0].prod, 16'h0000);
            chk("trunc 08x08", acc_log[1].prod, 16'h0040);
            chk("trunc 80x80", acc_log[2].prod, 16'h4000);
            chk("b2b consecutive", acc_log[2].cyc - acc_log[0].cyc, 2);
        end

        // Round-robin with all requesters valid
        do_reset();
        gnt_log.delete();
        acc_log.delete();
        req_valid = 4'hF;
        for (int r = 0; r < N; r++) set_op(r, 16 * r + 'h1F, 'hF0 - 'h11 * r);
        idle(8);
        req_valid = '0;
        idle(4);
        chk("rr grant count", gnt_log.size(), 8);
        chk("rr rsp count", acc_log.size(), 8);
        if (gnt_log.size() == 8 && acc_log.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("rr grant order", gnt_log[k], k % 4);
                chk("rr rsp_id order", acc_log[k].id, k % 4);
            end
        end

        // Backpressure with requesters 1 and 3
        gnt_log.delete();
        acc_log.delete();
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        set_op(1, 'h55, 'h99);
        set_op(3, 'hF0, 'h3C);
        idle(2);
        @(negedge clk);
        chk("bp stall rsp_id", rsp_id, 1);
        idle(2);
        @(negedge clk);
        chk("bp grants", gnt_log.size(), 2);
        chk("bp req_ready", req_ready, 0);
        chk("bp held prod", rsp_prod, 16'h2F80);
        step();
        rsp_ready = 1'b1;
        req_valid = '0;
        idle(4);
        chk("bp rsp count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            chk("bp first id", acc_log[0].id, 1);
            chk("bp second id", acc_log[1].id, 3);
            chk("bp second prod", acc_log[1].prod, 16'h3480);
        end

        // Reset with both stages full
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        set_op(3, 'h12, 'h34);
        idle(3);
        @(negedge clk);
        chk("mid busy", busy, 1);
        chk("mid req_ready", req_ready, 0);
        step();
        rst       = 1'b1;
        req_valid = 4'hF;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid rsp_valid", rsp_valid, 0);
        chk("mid busy after", busy, 0);
        chk("mid ops_count", ops_count, 0);
        chk("mid first grant", req_ready, 4'b0001);
        step();
        rsp_ready = 1'b1;
        req_valid = '0;
        idle(3);

        // Randomized traffic; operands stay put until granted, early drops allowed
        pend = '0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            gnt_seen = req_ready;
            step();
            rst = ($urandom_range(0, 399) == 0);
            for (int r = 0; r < N; r++) begin
                if (gnt_seen[r]) pend[r] = 1'b0;
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1'b1;
                    set_op(r, $urandom_range(0, 255), $urandom_range(0, 255));
                end else if (pend[r] && $urandom_range(0, 63) == 0) begin
                    pend[r] = 1'b0;
                end
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        step();
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        idle(3);

        // Saturation of ops_count
        do_reset();
        req_valid = 4'b0001;
        set_op(0, 'hFF, 'h08);
        idle(65536);
        @(negedge clk);
        chk("sat pre", ops_count, 16'hFFFE);
        idle(3);
        @(negedge clk);
        chk("sat ops_count", ops_count, 16'hFFFF);
        step();
        req_valid = '0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
